// File: rtl/wb_buffered_bridge.sv
// Same-clock Wishbone bridge: requests queue in a FIFO, posted writes ack on push,
// reads (and non-posted writes) ack once their own entry completes downstream.
module wb_buffered_bridge #(
  parameter int ADR_WIDTH     = 32,
  parameter int DAT_WIDTH     = 32,
  parameter int DEPTH         = 4,
  parameter bit POSTED_WRITES = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADR_WIDTH-1:0]   i_adr,
  input  logic [DAT_WIDTH-1:0]   i_dat_w,
  input  logic [DAT_WIDTH/8-1:0] i_sel,
  input  logic                   i_we,
  input  logic                   i_cyc,
  input  logic                   i_stb,
  output logic [DAT_WIDTH-1:0]   i_dat_r,
  output logic                   i_ack,
  output logic                   i_err,
  output logic [ADR_WIDTH-1:0]   t_adr,
  output logic [DAT_WIDTH-1:0]   t_dat_w,
  output logic [DAT_WIDTH/8-1:0] t_sel,
  output logic                   t_we,
  output logic                   t_cyc,
  output logic                   t_stb,
  input  logic [DAT_WIDTH-1:0]   t_dat_r,
  input  logic                   t_ack,
  input  logic                   t_err,
  output logic                   post_err,
  input  logic                   post_err_clr,
  output logic                   busy
);
  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat;
    logic [SEL_W-1:0]     sel;
    logic                 we;
  } req_t;

  typedef enum logic [1:0] {I_IDLE, I_WACK, I_RWAIT, I_RACK} i_state_t;
  typedef enum logic       {T_IDLE, T_BUSY}                  t_state_t;

  req_t             fifo [DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  i_state_t         i_state;
  t_state_t         t_state;
  logic             abandon;
  logic             full, push, pop, posted, last_done;

  assign full      = (count == CNT_W'(DEPTH));
  assign push      = (i_state == I_IDLE) && i_cyc && i_stb && !full;
  assign pop       = (t_state == T_BUSY) && (t_ack || t_err);
  assign posted    = POSTED_WRITES && i_we;
  // No pushes happen while waiting, so the waited-on entry pops exactly when it is the last one.
  assign last_done = pop && (count == CNT_W'(1));
  assign head      = fifo[rd_ptr];
  assign busy      = (count != '0) || (t_state == T_BUSY);

  always_ff @(posedge clock)
    if (push) fifo[wr_ptr] <= {i_adr, i_dat_w, i_sel, i_we};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Initiator side; abandon remembers an i_cyc drop so a late completion is never acked.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_state <= I_IDLE;
      i_ack   <= 1'b0;
      i_err   <= 1'b0;
      i_dat_r <= '0;
      abandon <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      case (i_state)
        I_IDLE:
          if (push) begin
            abandon <= 1'b0;
            if (posted) begin
              i_ack   <= 1'b1;
              i_state <= I_WACK;
            end else begin
              i_state <= I_RWAIT;
            end
          end
        I_WACK: i_state <= I_IDLE;
        I_RWAIT: begin
          if (!i_cyc) abandon <= 1'b1;
          if (last_done) begin
            i_dat_r <= t_dat_r;
            i_ack   <= !t_err && i_cyc && !abandon;
            i_err   <= t_err && i_cyc && !abandon;
            i_state <= I_RACK;
          end
        end
        I_RACK: i_state <= I_IDLE;
      endcase
    end
  end

  // Target side: one registered cycle per entry, t_cyc low for a cycle between entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_state  <= T_IDLE;
      t_adr    <= '0;
      t_dat_w  <= '0;
      t_sel    <= '0;
      t_we     <= 1'b0;
      t_cyc    <= 1'b0;
      t_stb    <= 1'b0;
      post_err <= 1'b0;
    end else begin
      post_err <= (pop && t_err && t_we && POSTED_WRITES) || (post_err && !post_err_clr);
      case (t_state)
        T_IDLE:
          if (count != '0) begin
            t_adr   <= head.adr;
            t_dat_w <= head.dat;
            t_sel   <= head.sel;
            t_we    <= head.we;
            t_cyc   <= 1'b1;
            t_stb   <= 1'b1;
            t_state <= T_BUSY;
          end
        T_BUSY:
          if (t_ack || t_err) begin
            t_cyc   <= 1'b0;
            t_stb   <= 1'b0;
            t_state <= T_IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_buffered_bridge.sv
// Bench for wb_buffered_bridge: posted (port 0) and non-posted (port 1) instances share
// one memory-backed target responder with programmable wait states, stalls and errors.
module tb_wb_buffered_bridge;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [31:0] i_adr, i_dat_w;
  logic [3:0]  i_sel;
  logic        i_we, post_err_clr;
  logic        i_cyc [2], i_stb [2];
  logic [31:0] i_dat_r [2];
  logic        i_ack [2], i_err [2], post_err [2], busy [2];
  logic [31:0] t_adr [2], t_dat_w [2], t_dat_r [2];
  logic [3:0]  t_sel [2];
  logic        t_we [2], t_cyc [2], t_stb [2], t_ack [2], t_err [2];

  wb_buffered_bridge #(.ADR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(4), .POSTED_WRITES(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we), .i_cyc(i_cyc[0]), .i_stb(i_stb[0]),
    .i_dat_r(i_dat_r[0]), .i_ack(i_ack[0]), .i_err(i_err[0]),
    .t_adr(t_adr[0]), .t_dat_w(t_dat_w[0]), .t_sel(t_sel[0]), .t_we(t_we[0]), .t_cyc(t_cyc[0]), .t_stb(t_stb[0]),
    .t_dat_r(t_dat_r[0]), .t_ack(t_ack[0]), .t_err(t_err[0]),
    .post_err(post_err[0]), .post_err_clr(post_err_clr), .busy(busy[0]));

  wb_buffered_bridge #(.ADR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(4), .POSTED_WRITES(0)) dut_np (
    .clock(clock), .reset_n(reset_n),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we), .i_cyc(i_cyc[1]), .i_stb(i_stb[1]),
    .i_dat_r(i_dat_r[1]), .i_ack(i_ack[1]), .i_err(i_err[1]),
    .t_adr(t_adr[1]), .t_dat_w(t_dat_w[1]), .t_sel(t_sel[1]), .t_we(t_we[1]), .t_cyc(t_cyc[1]), .t_stb(t_stb[1]),
    .t_dat_r(t_dat_r[1]), .t_ack(t_ack[1]), .t_err(t_err[1]),
    .post_err(post_err[1]), .post_err_clr(post_err_clr), .busy(busy[1]));

  // ---------------- target responder ----------------
  logic        stall, err_on;
  int          wait_cyc;
  int          wcnt [2];
  logic [31:0] mem [256];
  logic [31:0] log_adr [1024], log_dat [1024];
  logic        log_we [1024];
  int          log_n = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      t_ack[p]   = t_stb[p] && !stall && !err_on && (wcnt[p] >= wait_cyc);
      t_err[p]   = t_stb[p] && !stall && err_on && (wcnt[p] >= wait_cyc);
      t_dat_r[p] = mem[t_adr[p][9:2]];
    end
  end

  always @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (t_stb[p] && (t_ack[p] || t_err[p])) begin
        wcnt[p] <= 0;
        if (log_n < 1024) begin
          log_we[log_n[9:0]]  <= t_we[p];
          log_adr[log_n[9:0]] <= t_adr[p];
          log_dat[log_n[9:0]] <= t_dat_w[p];
        end
        log_n <= log_n + 1;
        if (t_we[p] && t_ack[p]) mem[t_adr[p][9:2]] <= merge(mem[t_adr[p][9:2]], t_dat_w[p], t_sel[p]);
      end else if (t_stb[p]) wcnt[p] <= wcnt[p] + 1;
      else wcnt[p] <= 0;
    end
  end

  function automatic logic [31:0] lga(input int i); return log_adr[i[9:0]]; endfunction
  function automatic logic [31:0] lgd(input int i); return log_dat[i[9:0]]; endfunction
  function automatic logic        lgw(input int i); return log_we[i[9:0]];  endfunction

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp); end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %b want %b", name, act, exp); end
  endtask
  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
  endtask

  // lat counts cycles from the first request cycle to the cycle showing i_ack/i_err (-1 = none).
  task automatic xfer(input int p, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output logic ack,
                      output logic err, output int lat);
    @(posedge clock); #1;
    i_adr = adr; i_dat_w = dat; i_sel = sel; i_we = we; i_cyc[p] = 1'b1; i_stb[p] = 1'b1;
    rd = '0; ack = 1'b0; err = 1'b0; lat = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (i_ack[p] || i_err[p]) begin rd = i_dat_r[p]; ack = i_ack[p]; err = i_err[p]; lat = k; break; end
    end
    @(posedge clock); #1;
    i_cyc[p] = 1'b0; i_stb[p] = 1'b0;
  endtask

  task automatic wait_idle(input int p);
    int n;
    n = 0;
    @(negedge clock);
    while ((busy[p] || i_ack[p] || i_err[p]) && n < 200) begin @(negedge clock); n++; end
    chk1("idle_within_bound", n < 200, 1'b1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wt;
    int          lat;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, adr, dat;
    logic [3:0]  sel;
    logic        ack, err, we;
    int          lat, n, base, idx;
    logic [31:0] ref_mem [16];
    logic [31:0] ex_adr [$], ex_dat [$];
    logic        ex_we [$];

    tbl[0] = '{1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0};
    tbl[1] = '{1'b0, 32'h40, 32'h0,        4'hF, 0, 3, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h44, 32'h12345678, 4'hF, 2, 1, 32'h0};
    tbl[3] = '{1'b1, 32'h44, 32'hAABBCCDD, 4'h5, 0, 1, 32'h0};
    tbl[4] = '{1'b0, 32'h44, 32'h0,        4'hF, 2, 5, 32'h12BB56DD};
    tbl[5] = '{1'b0, 32'h40, 32'h0,        4'hF, 1, 4, 32'hDEADBEEF};

    stall = 1'b0; err_on = 1'b0; wait_cyc = 0;
    reset_n = 1'b0; i_adr = '0; i_dat_w = '0; i_sel = '0; i_we = 1'b0; post_err_clr = 1'b0;
    for (int p = 0; p < 2; p++) begin i_cyc[p] = 1'b0; i_stb[p] = 1'b0; end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // reset state after 5 idle cycles
    repeat (5) @(negedge clock);
    for (int p = 0; p < 2; p++) begin
      chk32("rst_ctrl", 32'({i_ack[p], i_err[p], t_we[p], t_cyc[p], t_stb[p], post_err[p], busy[p], t_sel[p]}), 32'h0);
      chk32("rst_i_dat_r", i_dat_r[p], 32'h0);
      chk32("rst_t_adr", t_adr[p], 32'h0);
      chk32("rst_t_dat_w", t_dat_w[p], 32'h0);
    end

    // asynchronous reset while a target cycle is open
    stall = 1'b1;
    @(posedge clock); #1;
    i_adr = 32'h200; i_dat_w = 32'h1111; i_sel = 4'hF; i_we = 1'b1; i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!t_cyc[0] && n < 20);
    chk1("mr_tcyc_up", t_cyc[0], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("mr_tcyc_drop", t_cyc[0], 1'b0);
    chk1("mr_tstb_drop", t_stb[0], 1'b0);
    chk1("mr_busy_clear", busy[0], 1'b0);
    i_cyc[0] = 1'b0; i_stb[0] = 1'b0; stall = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;

    // single transfers on an idle bridge
    for (int i = 0; i < 6; i++) begin
      wait_cyc = tbl[i].wt;
      xfer(0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, ack, err, lat);
      chk_int("tbl_latency", lat, tbl[i].lat);
      chk32("tbl_resp", 32'({ack, err}), 32'h2);
      if (!tbl[i].we) chk32("tbl_rdata", rd, tbl[i].rd);
      wait_idle(0);
    end
    wait_cyc = 0;

    // FIFO fills behind a stalled target; 5th write waits for the first completion
    stall = 1'b1;
    base = log_n;
    for (int k = 0; k < 4; k++) begin
      xfer(0, 1'b1, 32'h20 + 32'(4*k), 32'h5000 + 32'(k), 4'hF, rd, ack, err, lat);
      chk_int("fill_write_lat", lat, 1);
    end
    @(posedge clock); #1;
    i_adr = 32'h30; i_dat_w = 32'h5004; i_sel = 4'hF; i_we = 1'b1; i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
    n = 0;
    repeat (8) begin @(negedge clock); if (i_ack[0]) n++; end
    chk_int("full_no_ack", n, 0);
    @(posedge clock); #1 stall = 1'b0;
    @(negedge clock);
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (i_ack[0]) begin lat = k; break; end
    end
    @(posedge clock); #1 i_cyc[0] = 1'b0; i_stb[0] = 1'b0;
    chk_int("fifth_ack_after_release", lat, 2);
    wait_idle(0);
    chk_int("fill_log_count", log_n - base, 5);
    for (int k = 0; k < 5; k++) chk32("fill_order_adr", lga(base + k), 32'h20 + 32'(4*k));

    // W, W, R ordering through the target
    base = log_n;
    xfer(0, 1'b1, 32'h10, 32'hA0A00010, 4'hF, rd, ack, err, lat);
    xfer(0, 1'b1, 32'h14, 32'hB0B00014, 4'hF, rd, ack, err, lat);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, ack, err, lat);
    chk32("wwr_rdata", rd, 32'hA0A00010);
    wait_idle(0);
    chk32("wwr_we_seq", 32'({lgw(base), lgw(base+1), lgw(base+2)}), 32'h6);
    chk32("wwr_adr0", lga(base), 32'h10);
    chk32("wwr_adr1", lga(base+1), 32'h14);
    chk32("wwr_adr2", lga(base+2), 32'h10);

    // posted-write errors
    err_on = 1'b1;
    xfer(0, 1'b1, 32'h80, 32'h1, 4'hF, rd, ack, err, lat);
    chk32("perr_resp_is_ack", 32'({ack, err}), 32'h2);
    wait_idle(0);
    chk1("perr_set", post_err[0], 1'b1);
    @(posedge clock); #1 post_err_clr = 1'b1;
    @(posedge clock); #1 post_err_clr = 1'b0;
    @(negedge clock);
    chk1("perr_cleared", post_err[0], 1'b0);
    xfer(0, 1'b1, 32'h80, 32'h2, 4'hF, rd, ack, err, lat);
    wait_idle(0);
    chk1("perr_set_again", post_err[0], 1'b1);
    fork
      xfer(0, 1'b1, 32'h80, 32'h3, 4'hF, rd, ack, err, lat);
      begin
        int m;
        m = 0;
        do begin @(negedge clock); m++; end while (!t_stb[0] && m < 50);
        chk1("perr_second_err_seen", t_err[0], 1'b1);
        post_err_clr = 1'b1;
        @(posedge clock); #1 post_err_clr = 1'b0;
      end
    join
    wait_idle(0);
    chk1("perr_set_wins", post_err[0], 1'b1);
    err_on = 1'b0;

    // non-posted instance: write error is returned as i_err
    err_on = 1'b1;
    xfer(1, 1'b1, 32'h84, 32'h9, 4'hF, rd, ack, err, lat);
    chk32("np_werr_resp", 32'({ack, err}), 32'h1);
    chk_int("np_werr_lat", lat, 3);
    @(negedge clock);
    chk1("np_werr_one_cycle", i_err[1], 1'b0);
    err_on = 1'b0;
    wait_idle(1);
    chk1("np_no_post_err", post_err[1], 1'b0);

    // read abandoned by dropping i_cyc while it waits
    stall = 1'b1;
    @(posedge clock); #1;
    i_adr = 32'h40; i_we = 1'b0; i_sel = 4'hF; i_cyc[1] = 1'b1; i_stb[1] = 1'b1;
    repeat (3) @(negedge clock);
    @(posedge clock); #1 i_cyc[1] = 1'b0; i_stb[1] = 1'b0;
    repeat (2) @(posedge clock);
    #1 stall = 1'b0;
    n = 0;
    repeat (10) begin @(negedge clock); if (i_ack[1] || i_err[1]) n++; end
    chk_int("abandon_no_resp", n, 0);
    wait_idle(1);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, rd, ack, err, lat);
    chk32("after_abandon_resp", 32'({ack, err}), 32'h2);
    chk32("after_abandon_rdata", rd, 32'hDEADBEEF);
    chk_int("after_abandon_lat", lat, 3);

    // randomized traffic against a word-array reference
    base = log_n;
    for (int i = 0; i < 16; i++) begin
      dat = $urandom;
      ref_mem[i] = dat;
      ex_adr.push_back(32'h100 + 32'(4*i)); ex_we.push_back(1'b1); ex_dat.push_back(dat);
      xfer(0, 1'b1, 32'h100 + 32'(4*i), dat, 4'hF, rd, ack, err, lat);
      chk32("rnd_init_resp", 32'({ack, err}), 32'h2);
    end
    for (int i = 0; i < 150; i++) begin
      we       = 1'($urandom_range(0, 1));
      idx      = $urandom_range(0, 15);
      adr      = 32'h100 + 32'(4*idx);
      dat      = $urandom;
      sel      = 4'($urandom_range(1, 15));
      wait_cyc = $urandom_range(0, 3);
      ex_adr.push_back(adr); ex_we.push_back(we); ex_dat.push_back(dat);
      xfer(0, we, adr, dat, sel, rd, ack, err, lat);
      chk32("rnd_resp", 32'({ack, err}), 32'h2);
      if (we) ref_mem[idx] = merge(ref_mem[idx], dat, sel);
      else chk32("rnd_rdata", rd, ref_mem[idx]);
    end
    wait_cyc = 0;
    wait_idle(0);
    chk_int("rnd_log_count", log_n - base, ex_adr.size());
    for (int i = 0; i < ex_adr.size(); i++) begin
      chk32("rnd_log_adr", lga(base + i), ex_adr[i]);
      chk1("rnd_log_we", lgw(base + i), ex_we[i]);
      if (ex_we[i]) chk32("rnd_log_dat", lgd(base + i), ex_dat[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_buffered_bridge.md
# wb_buffered_bridge

Single-clock Wishbone target-to-initiator bridge with a parametrised request FIFO, optional posted writes and registered outputs on both sides. It sits between an interconnect initiator and a slow or deeply pipelined target. It decouples write latency, preserves strict request ordering and breaks combinational paths across the boundary. It is the same-clock, buffered successor to the clock-domain bridge in this library, and drops into the same `i_`/`t_` port convention.

## Interface
- ADR_WIDTH, 32, address width
- DAT_WIDTH, 32, data width (multiple of 8); sel width is DAT_WIDTH/8
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- POSTED_WRITES, 1, 1: writes acked on FIFO push; 0: writes acked on target completion
---
- clock  in  1  sole clock; everything is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- i_adr / i_dat_w / i_sel / i_we / i_cyc / i_stb  in  ADR_WIDTH / DAT_WIDTH / DAT_WIDTH/8 / 1 / 1 / 1  target port, driven by the upstream initiator
- i_dat_r / i_ack / i_err  out  DAT_WIDTH / 1 / 1  target port responses
- t_adr / t_dat_w / t_sel / t_we / t_cyc / t_stb  out  ADR_WIDTH / DAT_WIDTH / DAT_WIDTH/8 / 1 / 1 / 1  initiator port, driving the downstream target
- t_dat_r / t_ack / t_err  in  DAT_WIDTH / 1 / 1  responses from the downstream target
- post_err  out  1  sticky flag: a posted write got t_err
- post_err_clr  in  1  clears post_err
- busy  out  1  FIFO non-empty or a target cycle is in flight

## Operation
- **FIFO entry:** {adr, dat_w, sel, we}. full = (count == DEPTH), evaluated on the current count. A push in the same cycle as a pop while full is refused.
- **Initiator FSM states:** I_IDLE, I_WACK, I_RWAIT, I_RACK.
  - I_IDLE, i_cyc & i_stb & !full: push. Posted write → I_WACK. Read, or write with POSTED_WRITES=0 → I_RWAIT.
  - I_WACK: i_ack=1 for this one cycle → I_IDLE. No accept occurs in I_WACK.
  - I_RWAIT: wait for completion of *this* entry on the target side. That entry is always the newest FIFO entry, because no further pushes are taken in I_RWAIT. On completion, capture t_dat_r into a register, latch err, → I_RACK.
  - I_RACK: drive i_ack (or i_err if err was latched) for one cycle with i_dat_r = captured data → I_IDLE.
  - If i_cyc is low in I_RACK, suppress the response and go to I_IDLE. The transaction was already performed at the target.
- **Target FSM states:** T_IDLE, T_BUSY.
  - T_IDLE, FIFO non-empty: register the head into t_adr/t_dat_w/t_sel/t_we, set t_cyc=t_stb=1 → T_BUSY.
  - T_BUSY, t_ack | t_err: clear t_cyc/t_stb, pop → T_IDLE. t_cyc is low for at least one cycle between transactions.
- **Posted-write errors:** t_err on a posted write sets post_err. post_err_clr clears it. Simultaneous set and clear: set wins.
- **Ordering:** strict FIFO order. A read returns only after all earlier posted writes have completed at the target.
- **i_dat_r:** holds its last captured value and is only meaningful while i_ack=1.
- **t_ outputs:** t_adr/t_dat_w/t_sel/t_we hold their value after a transaction completes.

## Timing
- **Reset values:** all outputs 0, FIFO empty, both FSMs idle, post_err=0.
- **Reset mid-operation:** on assertion, t_cyc/t_stb/i_ack/i_err drop immediately and all queued writes are discarded.
- **Posted write** sampled in cycle N: i_ack=1 in cycle N+1. With an empty FIFO, t_stb=1 in N+2.
- **Read** sampled in cycle N, with a zero-wait target (t_ack in the first t_stb cycle):
  - t_stb in N+2, t_ack in N+2.
  - i_ack in N+3, i_dat_r = t_dat_r sampled in N+2.
- **Target with W wait states:** i_ack in N+3+W. Each queued entry ahead of the read adds 2+W cycles.
- **Back-to-back posted writes:** at most one accept every 2 cycles (accept, then ack).
- **Target-side throughput:** one transaction every 2+W cycles.
- **busy:** busy = (count != 0) | (t_state == T_BUSY), registered-state derived with no input paths.

## Test plan
- Reset, then idle 5 cycles → all outputs 0 and busy=0. Assert reset_n low while t_cyc=1 → t_cyc is 0 with no clock edge.
- POSTED_WRITES=1, DEPTH=4, target stalls ack: issue 5 writes → 4 writes get i_ack. The 5th gets no ack until the first t_ack, then is acked 1 cycle after its accept.
- Writes to 0x10/0x14 followed by a read of 0x10, target memory model → t_ sequence is W,W,R in order and the read returns 0x10's written data.
- Zero-wait target, read of 0x40 returning 0xDEADBEEF sampled in cycle N → i_ack=1 and i_dat_r=0xDEADBEEF exactly in N+3.
- Target returns t_err on a posted write → post_err=1 and the initiator still saw i_ack. Pulse post_err_clr in the same cycle as a second error → post_err stays 1.
- POSTED_WRITES=0, t_err on a write → i_err=1 and i_ack=0 for one cycle. A read with i_cyc dropped during I_RWAIT → no i_ack, FSM back to I_IDLE, and the next request is accepted.
